byte_lane_data_memory: RTL and testbench
========================================

# byte_lane_data_memory

Parametrised data memory for the single-cycle/multicycle datapath. It replaces the plain single-port RAM with a byte-addressed memory that supports byte, halfword and word accesses with byte-lane writes and sign/zero extension on reads. Every access uses a req/ready handshake, has a registered one-cycle read latency, and is checked for misalignment and out-of-range addresses. It sits between the core's load/store unit and the memory array.

## Interface
Parameters:
- DATA_WIDTH, 32: word width in bits; multiple of 8, at least 16.
- ADDR_WIDTH, 32: byte address width of addr_i.
- MEMORY_DEPTH, 64: number of words; power of 2.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_i  in  1  access request.
- we_i  in  1  1 = write, 0 = read.
- size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (faults).
- unsigned_i  in  1  read extension: 1 = zero-extend, 0 = sign-extend.
- addr_i  in  ADDR_WIDTH  byte address.
- wdata_i  in  DATA_WIDTH  write data, right-aligned (byte in [7:0], half in [15:0]).
- ready_o  out  1  block can accept a request.
- rvalid_o  out  1  one-cycle pulse: read response valid.
- rdata_o  out  DATA_WIDTH  read data, right-aligned and extended.
- err_o  out  1  one-cycle pulse: the previous accepted access faulted.

## Operation
- Address split: OFS = log2(DATA_WIDTH/8) offset bits; word index = addr_i[OFS+log2(MEMORY_DEPTH)-1:OFS]; any set bit above the index field means out of range.
- A request is accepted when req_i && ready_o. A request while ready_o = 0 is ignored and gets no response.
- Fault conditions:
  - size_i = 11.
  - Half at an odd offset.
  - Word at a nonzero offset.
  - Out-of-range address.
- A faulting write leaves memory unchanged. A faulting read returns rvalid_o = 1, err_o = 1 and rdata_o = 0.
- Writes are little-endian: the byte goes to lane offset, the half goes to lanes offset and offset+1, the word goes to all lanes. Other lanes are untouched.
- Reads select the same lanes, right-align them, then extend per unsigned_i. Word reads are unaffected by unsigned_i.
- States: CLEAR (only when the macro is defined) and READY. Reset enters CLEAR, or READY when the macro is undefined. CLEAR moves to READY after the last word is cleared.
- rdata_o holds its last value between reads. A write never changes rdata_o.

## Timing
- Reset values: ready_o = 0, rvalid_o = 0, err_o = 0, rdata_o = 0, state and clear counter = 0. Reset takes effect immediately, without waiting for clk.
- ready_o goes to 1 on the first rising edge after rst_n deasserts. With the clear feature, this is delayed as described under Configuration.
- Access latency:
  - A read accepted at edge N gives rvalid_o = 1 and valid rdata_o after edge N+1.
  - err_o for any faulting access is asserted after edge N+1, for one cycle.
  - A write accepted at edge N updates the array at edge N.
- ready_o stays 1 while in READY. Back-to-back accesses are accepted every cycle.
- A read of an address written in the immediately preceding cycle returns the new data.
- Reset asserted mid-operation discards any pending response: no rvalid_o or err_o pulse follows. Array contents are kept unless the clear feature re-clears them.

## Configuration
- DMEM_CLEAR_ON_RESET_EN defined:
  - After rst_n release, the edge k (k = 1..MEMORY_DEPTH) writes zero to word k-1, with ready_o = 0 throughout.
  - ready_o goes to 1 after the edge that writes word MEMORY_DEPTH-1.
  - A reset during CLEAR restarts clearing from word 0.
- DMEM_CLEAR_ON_RESET_EN undefined: there is no CLEAR state or counter, and array contents are undefined after power-up.

## Test plan
All scenarios use DATA_WIDTH = 32, MEMORY_DEPTH = 64, ADDR_WIDTH = 32.
1. Word write 0x12345678 to 0x4, then word read at 0x4 -> one cycle later rvalid_o = 1, rdata_o = 0x12345678, err_o = 0.
2. Word write 0x00000000 to 0x8, byte write 0xAB to 0x9, then reads:
   - Word read at 0x8 -> 0x0000AB00.
   - Signed byte read at 0x9 -> 0xFFFFFFAB.
   - Unsigned byte read at 0x9 -> 0x000000AB.
3. Half write 0x8001 to 0x6, then signed half read at 0x6 -> 0xFFFF8001 and unsigned half read at 0x6 -> 0x00008001. Half read at 0x5 -> rvalid_o = 1, err_o = 1, rdata_o = 0.
4. Word write 0xDEADBEEF to 0x2, a size_i = 11 write to 0x4, and a word write to 0x100 -> err_o pulse for each; a word read at 0x4 still returns 0x12345678.
5. Continuous stream: write 0xA0A0A0A0 to 0x10 followed next cycle by a read of 0x10 -> rdata_o = 0xA0A0A0A0 after one cycle, with ready_o = 1 throughout.
6. rst_n low in the middle of a read stream:
   - Outputs go to 0 without waiting for clk, and no stale rvalid_o follows.
   - With DMEM_CLEAR_ON_RESET_EN: ready_o stays 0 for exactly 64 edges, and a word read at 0x4 then returns 0x00000000.
   - Without the macro: ready_o = 1 after the first edge.

Source files
------------

// File: rtl/byte_lane_data_memory_if.sv
// Load/store bus between the core's LSU (master) and byte_lane_data_memory (slave).
// Carries the req/ready request channel and the registered read/error response.
interface byte_lane_data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [1:0]            size_i;
  logic                  unsigned_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  ready_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  modport master (
    output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    input  ready_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
    output ready_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/byte_lane_data_memory.sv
// Byte-addressed data memory with byte/half/word lane writes, sign/zero
// extended reads, misalignment and range faults, and a two-stage response
// (request captured at edge N, response registered at edge N+1).
// Optional feature: define DMEM_CLEAR_ON_RESET_EN to zero the whole array
// after every reset before ready_o rises.
//
// state    | meaning
// CLEAR    | zeroing word clr_cnt_q, ready_o low (macro builds only)
// READY    | accepting one access per cycle
module byte_lane_data_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int MEMORY_DEPTH = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  byte_lane_data_memory_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFS  = $clog2(NB);
  localparam int IDXW = $clog2(MEMORY_DEPTH);
  localparam int LOW  = OFS + IDXW;

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

  logic                  ready_q, ready_d;
  logic                  pend_q, pend_d;
  logic                  pend_we_q, pend_we_d;
  logic                  pend_fault_q, pend_fault_d;
  logic                  pend_uns_q, pend_uns_d;
  logic [1:0]            pend_size_q, pend_size_d;
  logic [OFS-1:0]        pend_off_q, pend_off_d;
  logic [IDXW-1:0]       pend_idx_q, pend_idx_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  accept;
  logic                  fault;
  logic [OFS-1:0]        off;
  logic [IDXW-1:0]       idx;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic [NB-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_sh, rd_ext;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  logic [0:0]      state_q, state_d;
  logic [IDXW-1:0] clr_cnt_q, clr_cnt_d;
`endif

  assign accept = bus.req_i && ready_q;

  // Address split, lane enables and fault decode for the incoming request.
  always_comb begin
    off      = bus.addr_i[OFS-1:0];
    idx      = bus.addr_i[LOW-1:OFS];
    addr_hi  = bus.addr_i >> LOW;
    fault    = |addr_hi;
    be       = '0;
    wdata_sh = bus.wdata_i << {off, 3'b000};
    case (bus.size_i)
      2'b00: be = NB'(1) << off;
      2'b01: begin
        be = NB'(3) << off;
        if (off[0]) fault = 1'b1;
      end
      2'b10: begin
        be = '1;
        if (|off) fault = 1'b1;
      end
      default: fault = 1'b1;
    endcase
  end

  // Right-align the selected lanes of the pending read and extend them.
  always_comb begin
    rd_sh  = mem_q[pend_idx_q] >> {pend_off_q, 3'b000};
    rd_ext = rd_sh;
    case (pend_size_q)
      2'b00:   for (int i = 8; i < DATA_WIDTH; i++) rd_ext[i] = rd_sh[7] & ~pend_uns_q;
      2'b01:   for (int i = 16; i < DATA_WIDTH; i++) rd_ext[i] = rd_sh[15] & ~pend_uns_q;
      default: rd_ext = rd_sh;
    endcase
  end

  // Next-state: ready/clear sequencing, request capture, response stage.
  always_comb begin
    ready_d      = 1'b1;
`ifdef DMEM_CLEAR_ON_RESET_EN
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    ready_d      = ready_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == IDXW'(MEMORY_DEPTH - 1)) begin
        state_d = ST_READY;
        ready_d = 1'b1;
      end
    end
`endif
    pend_d       = accept;
    pend_we_d    = bus.we_i;
    pend_fault_d = fault;
    pend_uns_d   = bus.unsigned_i;
    pend_size_d  = bus.size_i;
    pend_off_d   = off;
    pend_idx_d   = idx;
    rvalid_d     = pend_q && !pend_we_q;
    err_d        = pend_q && pend_fault_q;
    rdata_d      = rdata_q;
    if (rvalid_d) rdata_d = pend_fault_q ? '0 : rd_ext;
  end

  // Control and response registers; reset drops any in-flight response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b0;
      pend_q       <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_fault_q <= 1'b0;
      pend_uns_q   <= 1'b0;
      pend_size_q  <= '0;
      pend_off_q   <= '0;
      pend_idx_q   <= '0;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
`ifdef DMEM_CLEAR_ON_RESET_EN
      state_q      <= ST_CLEAR;
      clr_cnt_q    <= '0;
`endif
    end else begin
      ready_q      <= ready_d;
      pend_q       <= pend_d;
      pend_we_q    <= pend_we_d;
      pend_fault_q <= pend_fault_d;
      pend_uns_q   <= pend_uns_d;
      pend_size_q  <= pend_size_d;
      pend_off_q   <= pend_off_d;
      pend_idx_q   <= pend_idx_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
`ifdef DMEM_CLEAR_ON_RESET_EN
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
`endif
    end
  end

  // Array writes: lane-masked stores at accept time, plus the clear sweep.
  always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
    if (rst_n && state_q == ST_CLEAR) mem_q[clr_cnt_q] <= '0;
`endif
    if (accept && bus.we_i && !fault) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
      end
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.rvalid_o = rvalid_q;
  assign bus.err_o    = err_q;
  assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Directed bench for byte_lane_data_memory (32-bit data, 64 words).
module tb_byte_lane_data_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic early_rv;

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam int          EXP_EDGES  = 64;
  localparam logic [31:0] EXP_W4_RST = 32'h0000_0000;
  localparam logic [31:0] EXP_W10_RST = 32'h0000_0000;
`else
  localparam int          EXP_EDGES  = 1;
  localparam logic [31:0] EXP_W4_RST = 32'h1234_5678;
  localparam logic [31:0] EXP_W10_RST = 32'hA0A0_A0A0;
`endif

  byte_lane_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  byte_lane_data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEMORY_DEPTH(64)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic req, input logic we, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_i = req; bus.we_i = we; bus.size_i = size;
    bus.unsigned_i = uns; bus.addr_i = addr; bus.wdata_i = wdata;
  endtask

  // One isolated access; returns #1 after the response edge (N+1).
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    drive(1'b1, we, size, uns, addr, wdata);
    @(posedge clk); #1;
    early_rv = bus.rvalid_o;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    int stale = 0;
    while (n < 200) begin
      @(posedge clk); #1;
      n++;
      if (bus.rvalid_o || bus.err_o) stale++;
      if (bus.ready_o) break;
    end
    checks++;
    if (n !== EXP_EDGES) begin
      failures++;
      $display("FAIL %s_edges got=%0d exp=%0d", name, n, EXP_EDGES);
    end
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("FAIL %s_stale got=%0d exp=0", name, stale);
    end
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", {31'b0, bus.ready_o}, 32'h0);
    chk("rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    chk("rst_err", {31'b0, bus.err_o}, 32'h0);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    wait_ready("rst");
  endtask

  task automatic test_word();
    access(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678);
    chk("t1_wr_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    chk("t1_wr_err", {31'b0, bus.err_o}, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("t1_early_rvalid", {31'b0, early_rv}, 32'h0);
    chk("t1_rvalid", {31'b0, bus.rvalid_o}, 32'h1);
    chk("t1_err", {31'b0, bus.err_o}, 32'h0);
    chk("t1_rdata", bus.rdata_o, 32'h1234_5678);
    @(posedge clk); #1;
    chk("t1_rvalid_pulse", {31'b0, bus.rvalid_o}, 32'h0);
    chk("t1_rdata_hold", bus.rdata_o, 32'h1234_5678);
  endtask

  task automatic test_byte();
    access(1'b1, 2'b10, 1'b0, 32'h8, 32'h0000_0000);
    access(1'b1, 2'b00, 1'b0, 32'h9, 32'hFFFF_FFAB);
    chk("t2_wr_rdata_hold", bus.rdata_o, 32'h1234_5678);
    access(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
    chk("t2_word", bus.rdata_o, 32'h0000_AB00);
    access(1'b0, 2'b00, 1'b0, 32'h9, 32'h0);
    chk("t2_sbyte", bus.rdata_o, 32'hFFFF_FFAB);
    access(1'b0, 2'b00, 1'b1, 32'h9, 32'h0);
    chk("t2_ubyte", bus.rdata_o, 32'h0000_00AB);
    access(1'b0, 2'b01, 1'b0, 32'h8, 32'h0);
    chk("t2_shalf", bus.rdata_o, 32'hFFFF_AB00);
    access(1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
    chk("t2_byte0", bus.rdata_o, 32'h0000_0000);
  endtask

  task automatic test_half();
    access(1'b1, 2'b01, 1'b0, 32'h6, 32'h5A5A_8001);
    access(1'b0, 2'b01, 1'b0, 32'h6, 32'h0);
    chk("t3_shalf", bus.rdata_o, 32'hFFFF_8001);
    access(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
    chk("t3_uhalf", bus.rdata_o, 32'h0000_8001);
    access(1'b0, 2'b01, 1'b0, 32'h4, 32'h0);
    chk("t3_lowhalf", bus.rdata_o, 32'h0000_5678);
    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("t3_word", bus.rdata_o, 32'h8001_5678);
    access(1'b0, 2'b01, 1'b0, 32'h5, 32'h0);
    chk("t3_mis_rvalid", {31'b0, bus.rvalid_o}, 32'h1);
    chk("t3_mis_err", {31'b0, bus.err_o}, 32'h1);
    chk("t3_mis_rdata", bus.rdata_o, 32'h0);
  endtask

  task automatic test_faults();
    access(1'b1, 2'b10, 1'b0, 32'h0, 32'h1111_1111);
    access(1'b1, 2'b10, 1'b0, 32'h4, 32'h1234_5678);
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("t4_base", bus.rdata_o, 32'h1111_1111);
    access(1'b1, 2'b10, 1'b0, 32'h2, 32'hDEAD_BEEF);
    chk("t4_mis_err", {31'b0, bus.err_o}, 32'h1);
    chk("t4_mis_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    chk("t4_mis_rdata_hold", bus.rdata_o, 32'h1111_1111);
    @(posedge clk); #1;
    chk("t4_err_pulse", {31'b0, bus.err_o}, 32'h0);
    access(1'b1, 2'b11, 1'b0, 32'h4, 32'hFFFF_FFFF);
    chk("t4_rsv_err", {31'b0, bus.err_o}, 32'h1);
    access(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFE_F00D);
    chk("t4_oor_err", {31'b0, bus.err_o}, 32'h1);
    access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    chk("t4_w0_kept", bus.rdata_o, 32'h1111_1111);
    chk("t4_w0_err", {31'b0, bus.err_o}, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("t4_w4_kept", bus.rdata_o, 32'h1234_5678);
    access(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    chk("t4_rsv_rd_err", {31'b0, bus.err_o}, 32'h1);
    chk("t4_rsv_rd_rdata", bus.rdata_o, 32'h0);
    access(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
    chk("t4_oor_rd_err", {31'b0, bus.err_o}, 32'h1);
    chk("t4_oor_rd_rvalid", {31'b0, bus.rvalid_o}, 32'h1);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hA0A0_A0A0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("t5_ready_a", {31'b0, bus.ready_o}, 32'h1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("t5_ready_b", {31'b0, bus.ready_o}, 32'h1);
    chk("t5_wr_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("t5_ready_c", {31'b0, bus.ready_o}, 32'h1);
    chk("t5_rvalid_a", {31'b0, bus.rvalid_o}, 32'h1);
    chk("t5_rdata_a", bus.rdata_o, 32'hA0A0_A0A0);
    @(posedge clk); #1;
    chk("t5_rvalid_b", {31'b0, bus.rvalid_o}, 32'h1);
    chk("t5_rdata_b", bus.rdata_o, 32'h1234_5678);
    @(posedge clk); #1;
    chk("t5_rvalid_end", {31'b0, bus.rvalid_o}, 32'h0);
    chk("t5_rdata_hold", bus.rdata_o, 32'h1234_5678);
  endtask

  task automatic test_reset_mid_stream();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_pre_rvalid", {31'b0, bus.rvalid_o}, 32'h1);
    chk("t6_pre_rdata", bus.rdata_o, 32'h1234_5678);
    #2 rst_n = 1'b0;
    #1;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    chk("t6_async_ready", {31'b0, bus.ready_o}, 32'h0);
    chk("t6_async_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    chk("t6_async_rdata", bus.rdata_o, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6_hold_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    wait_ready("t6");
    access(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    chk("t6_w4", bus.rdata_o, EXP_W4_RST);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("t6_w10", bus.rdata_o, EXP_W10_RST);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_faults();
    test_back_to_back();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
